// File: rtl/row_mac_accum_if.sv
// rtl/row_mac_accum_if.sv - chunk-in / row-result bus for row_mac_accum
interface row_mac_accum_if #(
  parameter int DW = 48,
  parameter int AW = 24,
  parameter int CW = 2
);
  logic [DW-1:0] dataI;
  logic [DW-1:0] weightI;
  logic          in_valid;
  logic          flush;
  logic [AW-1:0] FinalOutput;
  logic          out_valid;
  logic [CW-1:0] chunk_idx;
  logic          busy;
  logic          overflow;

  modport master (
    output dataI, weightI, in_valid, flush,
    input  FinalOutput, out_valid, chunk_idx, busy, overflow
  );

  modport slave (
    input  dataI, weightI, in_valid, flush,
    output FinalOutput, out_valid, chunk_idx, busy, overflow
  );
endinterface

// File: rtl/row_mac_accum.sv
// rtl/row_mac_accum.sv - lane-wise multiply of a 4-chunk row, pipelined row sum
module row_mac_accum #(
  parameter int LANES  = 6,
  parameter int LW     = 8,
  parameter int CHUNKS = 4,
  parameter int ACC_W  = 24
) (
  input logic           clock,
  input logic           reset,
  row_mac_accum_if.slave bus
);
  localparam int PW = 2 * LW;
  localparam int SW = PW + $clog2(LANES);
  localparam int CW = $clog2(CHUNKS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic [CW-1:0]  LAST_IDX = CW'(CHUNKS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [0:0]    state;
  logic [CW-1:0] idx;
  logic          accept;

  logic [PW-1:0] prod_c [LANES];
  logic [PW-1:0] s1_prod [LANES];
  logic          s1_valid;
  logic          s1_first;
  logic          s1_last;

  logic [SW-1:0] sum_c;
  logic [SW-1:0] s2_sum;
  logic          s2_valid;
  logic          s2_first;
  logic          s2_last;

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   total_c;
  logic [ACC_W-1:0] next_acc_c;
  logic             sat_c;
  logic [ACC_W-1:0] final_q;
  logic             out_valid_q;
  logic             overflow_q;

  // flush beats a coincident chunk strobe
  assign accept = bus.in_valid & ~bus.flush;

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (bus.in_valid) begin
      if (idx == LAST_IDX) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else begin
        state <= ST_ACCUM;
        idx   <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_c[k] = PW'(bus.dataI[k*LW +: LW]) * PW'(bus.weightI[k*LW +: LW]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        s1_prod[k] <= prod_c[k];
      end
      s1_first <= (idx == '0);
      s1_last  <= (idx == LAST_IDX);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_c = sum_c + SW'(s1_prod[k]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (s1_valid) begin
      s2_sum   <= sum_c;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // A first-tagged chunk loads rather than adds, so rows can abut without a bubble.
  always_comb begin
    total_c    = (s2_first ? '0 : {1'b0, acc}) + (ACC_W+1)'(s2_sum);
    sat_c      = total_c[ACC_W];
    next_acc_c = sat_c ? ACC_MAX : total_c[ACC_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      final_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.flush) begin
      acc         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s2_valid & s2_last;
      if (s2_valid) begin
        acc        <= next_acc_c;
        overflow_q <= s2_first ? sat_c : (overflow_q | sat_c);
        if (s2_last) begin
          final_q <= next_acc_c;
        end
      end
    end
  end

  assign bus.FinalOutput = final_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.chunk_idx   = idx;
  assign bus.busy        = (idx != '0) | s1_valid | s2_valid;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_row_mac_accum.sv
// tb/tb_row_mac_accum.sv - scoreboard bench for row_mac_accum
module tb_row_mac_accum;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  row_mac_accum_if bus ();

  row_mac_accum dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    longint      sum;
    bit          ovf;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int          chunk_cnt = 0;
  longint      row_acc  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected row, on time.
  always @(negedge clock) begin
    if (!reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("final_output", longint'(bus.FinalOutput), e.sum);
        check("overflow_at_result", longint'(bus.overflow), longint'(e.ovf));
        check("result_latency_cycle", longint'(cyc), longint'(e.due));
      end
    end
    if (sb.size() > 0 && cyc > sb[0].due) begin
      check("missing_out_valid", 0, 1);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [47:0] splat(input logic [7:0] v);
    return {6{v}};
  endfunction

  task automatic model_accept(input logic [47:0] d, input logic [47:0] w);
    for (int k = 0; k < 6; k++) begin
      row_acc += longint'(d[k*8 +: 8]) * longint'(w[k*8 +: 8]);
    end
    chunk_cnt++;
    if (chunk_cnt == 4) begin
      exp_t e;
      e.ovf = (row_acc > 64'd16777215);
      e.sum = e.ovf ? 64'd16777215 : row_acc;
      e.due = cyc + 2;
      sb.push_back(e);
      chunk_cnt = 0;
      row_acc   = 0;
    end
  endtask

  task automatic send_chunk(input logic [47:0] d, input logic [47:0] w);
    bus.dataI    = d;
    bus.weightI  = w;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    model_accept(d, w);
    check("chunk_idx", longint'(bus.chunk_idx), longint'(chunk_cnt));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drop_in_flight();
    chunk_cnt = 0;
    row_acc   = 0;
    while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
  endtask

  task automatic do_flush(input logic with_valid);
    bus.flush    = 1'b1;
    bus.in_valid = with_valid;
    bus.dataI    = 48'($urandom);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    drop_in_flight();
    check("chunk_idx_after_flush", longint'(bus.chunk_idx), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drop_in_flight();
  endtask

  task automatic check_reset_values();
    check("rst_final_output", longint'(bus.FinalOutput), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_chunk_idx", longint'(bus.chunk_idx), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_overflow", longint'(bus.overflow), 0);
  endtask

  task automatic send_row(input logic [7:0] d, input logic [7:0] w);
    for (int c = 0; c < 4; c++) send_chunk(splat(d), splat(w));
  endtask

  initial begin
    bus.dataI    = '0;
    bus.weightI  = '0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values();

    // all-ones row, then max-operand row
    send_row(8'd1, 8'd1);
    idle(4);
    check("ones_overflow", longint'(bus.overflow), 0);
    send_row(8'd255, 8'd255);
    idle(4);
    check("max_row_held", longint'(bus.FinalOutput), 64'h17D018);

    // back-to-back rows, expecting 48 then 72
    send_row(8'd1, 8'd2);
    send_row(8'd3, 8'd1);
    idle(4);
    check("row_b_held", longint'(bus.FinalOutput), 72);

    // gapped row: chunks on relative cycles 0,3,4,9; busy must stay up until the result
    send_chunk(splat(8'd2), splat(8'd2));
    for (int i = 0; i < 2; i++) begin
      check("busy_gap_a", longint'(bus.busy), 1);
      tick();
    end
    send_chunk(splat(8'd2), splat(8'd2));
    send_chunk(splat(8'd2), splat(8'd2));
    for (int i = 0; i < 4; i++) begin
      check("busy_gap_b", longint'(bus.busy), 1);
      tick();
    end
    send_chunk(splat(8'd2), splat(8'd2));
    check("busy_pipe_s1", longint'(bus.busy), 1);
    tick();
    check("busy_pipe_s2", longint'(bus.busy), 1);
    tick();
    check("gap_row_out_valid", longint'(bus.out_valid), 1);
    check("gap_row_result", longint'(bus.FinalOutput), 96);
    idle(3);

    // flush mid-row with a coincident chunk
    send_row(8'd1, 8'd1);
    idle(3);
    send_chunk(splat(8'd9), splat(8'd9));
    send_chunk(splat(8'd9), splat(8'd9));
    do_flush(1'b1);
    idle(3);
    check("flush_holds_result", longint'(bus.FinalOutput), 24);
    check("flush_busy", longint'(bus.busy), 0);
    send_row(8'd1, 8'd1);
    idle(4);

    // reset after two chunks
    send_chunk(splat(8'd7), splat(8'd5));
    send_chunk(splat(8'd7), splat(8'd5));
    do_reset();
    check_reset_values();
    idle(3);
    send_row(8'd1, 8'd1);
    idle(4);
    check("post_reset_row", longint'(bus.FinalOutput), 24);

    // randomized rows with gaps and occasional flushes
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 4; c++) begin
        int g;
        g = int'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) do_flush(1'($urandom));
        idle(g);
        send_chunk(48'($urandom) | (48'($urandom) << 32), 48'($urandom) | (48'($urandom) << 32));
      end
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
    end
    idle(6);
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
